// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA block sequencer: FSM states, block/word widths
// and the default WAIT timeout.
package tea_pkg;

  localparam int unsigned BlockW           = 64;
  localparam int unsigned WordW            = 32;
  localparam int unsigned WaitLimitDefault = 1023;

  typedef logic [BlockW-1:0] block_t;
  typedef logic [WordW-1:0]  word_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGotL  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StOutL  = 3'd4,
    StOutR  = 3'd5
  } seq_state_e;

  // CBC whitening of a plaintext block; ECB passes the block through untouched.
  function automatic block_t cbc_whiten(input block_t data, input block_t chain, input logic cbc);
    return cbc ? (data ^ chain) : data;
  endfunction

endpackage

// File: rtl/tea_wait_timer.sv
// WAIT-state cycle counter. Counts from 0 while i_run is high and flags the last permitted
// cycle, so the sequencer spends at most WAIT_LIMIT cycles waiting for the core.
module tea_wait_timer
  import tea_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WaitLimitDefault
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned     CntW    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_LIMIT - 1);

  logic [CntW-1:0] r_count_q;
  logic [CntW-1:0] w_count_d;

  // Clearing whenever idle guarantees the count starts at 0 on every WAIT entry.
  always_comb begin
    w_count_d = '0;
    if (i_run) begin
      w_count_d = r_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= w_count_d;
    end
  end

  assign o_expired = i_run && (r_count_q == LastCnt);

endmodule

// File: rtl/tea_block_sequencer.sv
// Packs two 32-bit words into a 64-bit TEA block, optionally CBC-chains it, runs the
// external TEA core and streams the ciphertext back out as two 32-bit words.
module tea_block_sequencer
  import tea_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WaitLimitDefault,
  parameter bit          CBC_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WordW-1:0]  in_data,
  input  logic              cbc_mode,
  input  logic              iv_load,
  input  logic [BlockW-1:0] iv,
  output logic              tea_start,
  output logic [BlockW-1:0] tea_plain,
  input  logic              tea_done,
  input  logic [BlockW-1:0] tea_cipher,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WordW-1:0]  out_data,
  output logic              timeout
);

  seq_state_e r_state_q;
  seq_state_e w_state_d;

  logic              r_alive_q;
  logic [WordW-1:0]  r_left_q;
  logic              r_cbc_q;
  logic [BlockW-1:0] r_chain_q;
  logic [BlockW-1:0] r_plain_q;
  logic [BlockW-1:0] r_cipher_q;
  logic              r_timeout_q;

  logic w_accept;
  logic w_in_wait;
  logic w_expired;
  logic w_done_hit;
  logic w_timeout_hit;

  assign w_accept      = in_valid && in_ready;
  assign w_done_hit    = w_in_wait && tea_done;
  assign w_timeout_hit = w_expired && !tea_done;

  tea_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_run    (w_in_wait),
    .o_expired(w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= StIdle;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StIdle:  if (w_accept) w_state_d = StGotL;
      StGotL:  if (w_accept) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait: begin
        if (tea_done) begin
          w_state_d = StOutL;
        end else if (w_expired) begin
          w_state_d = StIdle;
        end
      end
      StOutL:  if (out_ready) w_state_d = StOutR;
      StOutR:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic; in_ready stays low until the first edge after reset release.
  always_comb begin
    in_ready  = 1'b0;
    tea_start = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    w_in_wait = 1'b0;
    unique case (r_state_q)
      StIdle, StGotL: in_ready = r_alive_q;
      StIssue:        tea_start = 1'b1;
      StWait:         w_in_wait = 1'b1;
      StOutL: begin
        out_valid = 1'b1;
        out_data  = r_cipher_q[BlockW-1:WordW];
      end
      StOutR: begin
        out_valid = 1'b1;
        out_data  = r_cipher_q[WordW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive_q   <= 1'b0;
      r_timeout_q <= 1'b0;
    end else begin
      r_alive_q <= 1'b1;
      if (w_timeout_hit) begin
        r_timeout_q <= 1'b1;
      end
    end
  end

  // Word capture and block assembly; the right word lands directly in the plain register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_left_q  <= '0;
      r_cbc_q   <= 1'b0;
      r_plain_q <= '0;
    end else begin
      if (r_state_q == StIdle && w_accept) begin
        r_left_q <= in_data;
        r_cbc_q  <= CBC_EN && cbc_mode;
      end
      if (r_state_q == StGotL && w_accept) begin
        r_plain_q <= cbc_whiten({r_left_q, in_data}, r_chain_q, r_cbc_q);
      end
    end
  end

  // An IV load in IDLE lands before the block's XOR, which happens on the second accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain_q  <= '0;
      r_cipher_q <= '0;
    end else begin
      if (CBC_EN && r_state_q == StIdle && iv_load) begin
        r_chain_q <= iv;
      end else if (w_done_hit && r_cbc_q) begin
        r_chain_q <= tea_cipher;
      end
      if (w_done_hit) begin
        r_cipher_q <= tea_cipher;
      end
    end
  end

  assign tea_plain = r_plain_q;
  assign timeout   = r_timeout_q;

endmodule

// File: tb/tb_tea_block_sequencer.sv
// Scoreboard bench for tea_block_sequencer with a stub TEA core (done 4 edges after it
// samples start, cipher = ~plain).
module tb_tea_block_sequencer;

  localparam int unsigned WaitLim = 15;
  localparam int          Bound   = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        cbc_mode = 1'b0;
  logic        iv_load = 1'b0;
  logic [63:0] iv = '0;
  logic        tea_start;
  logic [63:0] tea_plain;
  logic        tea_done = 1'b0;
  logic [63:0] tea_cipher = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        timeout;

  tea_block_sequencer #(
    .WAIT_LIMIT(WaitLim),
    .CBC_EN    (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cbc_mode  (cbc_mode),
    .iv_load   (iv_load),
    .iv        (iv),
    .tea_start (tea_start),
    .tea_plain (tea_plain),
    .tea_done  (tea_done),
    .tea_cipher(tea_cipher),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core; deliberately not reset so a late done can hit an idle sequencer.
  logic       stub_mute = 1'b0;
  logic       stub_busy = 1'b0;
  logic [2:0] stub_cnt = '0;
  always @(posedge clk) begin
    tea_done <= 1'b0;
    if (tea_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 3'd1;
    end else if (stub_busy) begin
      if (stub_cnt == 3'd4) begin
        stub_busy  <= 1'b0;
        tea_done   <= !stub_mute;
        tea_cipher <= ~tea_plain;
      end else begin
        stub_cnt <= stub_cnt + 3'd1;
      end
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          last_acc = 0;
  logic [31:0] exp_out_q[$];
  logic [63:0] exp_plain_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts the core or hands off a word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tea_start) begin
        if (exp_plain_q.size() == 0) begin
          flag("tea_plain", $sformatf("start with plain 0x%0h, want no start", tea_plain));
        end else begin
          chk("tea_plain", tea_plain, exp_plain_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          flag("out_data", $sformatf("word 0x%0h, want no output", out_data));
        end else begin
          chk("out_data", {32'h0, out_data}, {32'h0, exp_out_q.pop_front()});
        end
      end
    end
  end

  // All tasks below run in the phase just after a rising edge.
  task automatic send(input logic [31:0] d, input logic mode, input logic ivl,
                      input logic [63:0] ivv);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    cbc_mode = mode;
    iv_load  = ivl;
    iv       = ivv;
    k = 0;
    while (!in_ready && k < Bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= Bound) flag("in_ready_wait", "in_ready stayed 0, want 1");
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    iv_load  = 1'b0;
  endtask

  task automatic run_block(input logic [31:0] l, input logic [31:0] r, input logic mode,
                           input logic ivl, input logic [63:0] ivv);
    send(l, mode, ivl, ivv);
    send(r, mode, 1'b0, 64'h0);
  endtask

  task automatic wait_valid(output int at);
    int k = 0;
    while (!out_valid && k < Bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= Bound) flag("out_valid_wait", "out_valid stayed 0, want 1");
    at = cyc;
  endtask

  task automatic wait_start(output int at);
    int k = 0;
    while (!tea_start && k < Bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= Bound) flag("tea_start_wait", "tea_start stayed 0, want 1");
    at = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(in_ready && !out_valid) && k < Bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= Bound) flag("idle_wait", "sequencer never returned to idle, want idle");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_tea_start"}, tea_start, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_tea_plain"}, tea_plain, 64'h0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1);
  end

  initial begin
    int t;
    int s;

    #2;
    chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1);

    // ECB block with latency measurement.
    exp_plain_q.push_back(64'h0123456789ABCDEF);
    exp_out_q.push_back(32'hFEDCBA98);
    exp_out_q.push_back(32'h76543210);
    run_block(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 64'h0);
    wait_valid(t);
    chk("latency", t - last_acc, 6);
    wait_idle();

    // CBC: IV loaded with the first word, then a chained second block.
    exp_plain_q.push_back(64'hFFFFFFFF00000000);
    exp_out_q.push_back(32'h00000000);
    exp_out_q.push_back(32'hFFFFFFFF);
    run_block(32'h0, 32'h0, 1'b1, 1'b1, 64'hFFFFFFFF00000000);
    wait_idle();
    exp_plain_q.push_back(64'h00000000FFFFFFFF);
    exp_out_q.push_back(32'hFFFFFFFF);
    exp_out_q.push_back(32'h00000000);
    run_block(32'h0, 32'h0, 1'b1, 1'b0, 64'h0);
    wait_idle();

    // ECB block: iv_load during WAIT, then a 5-cycle output stall.
    out_ready = 1'b0;
    exp_plain_q.push_back(64'h13579BDF2468ACE0);
    exp_out_q.push_back(32'hECA86420);
    exp_out_q.push_back(32'hDB97531F);
    run_block(32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b0, 64'h0);
    wait_start(s);
    @(posedge clk);
    #1;
    iv_load = 1'b1;
    iv      = 64'h5555555555555555;
    repeat (2) @(posedge clk);
    #1;
    iv_load = 1'b0;
    wait_valid(t);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_data", out_data, 32'hECA86420);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_idle();
    chk("after_stall_in_ready", in_ready, 1);

    // Chain must still hold the block-2 cipher: the WAIT-time IV load was ignored.
    exp_plain_q.push_back(64'hFFFFFFFF00000000);
    exp_out_q.push_back(32'h00000000);
    exp_out_q.push_back(32'hFFFFFFFF);
    run_block(32'h0, 32'h0, 1'b1, 1'b0, 64'h0);
    wait_idle();

    // IV loaded together with the first-word accept is used by that block.
    exp_plain_q.push_back(64'h10325476AB89EFCD);
    exp_out_q.push_back(32'hEFCDAB89);
    exp_out_q.push_back(32'h54761032);
    run_block(32'h11111111, 32'h22222222, 1'b1, 1'b1, 64'h0123456789ABCDEF);
    wait_idle();

    // Core never answers: timeout after WAIT_LIMIT cycles in WAIT.
    stub_mute = 1'b1;
    exp_plain_q.push_back(64'hDEADBEEF00C0FFEE);
    run_block(32'hDEADBEEF, 32'h00C0FFEE, 1'b0, 1'b0, 64'h0);
    wait_start(s);
    repeat (15) @(posedge clk);
    #1;
    chk("timeout_early", timeout, 0);
    @(posedge clk);
    #1;
    chk("timeout_set", timeout, 1);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_sticky", timeout, 1);
    stub_mute = 1'b0;

    // Reset during WAIT; the stub's late done must be ignored.
    exp_plain_q.push_back(64'hA5A5A5A55A5A5A5A);
    run_block(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 64'h0);
    wait_start(s);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("late_done_out_valid", out_valid, 0);
    chk("late_done_in_ready", in_ready, 1);

    exp_plain_q.push_back(64'hCAFEF00D8BADF00D);
    exp_out_q.push_back(32'h35010FF2);
    exp_out_q.push_back(32'h74520FF2);
    run_block(32'hCAFEF00D, 32'h8BADF00D, 1'b0, 1'b0, 64'h0);
    wait_idle();

    // Reset during OUT_R: the right word must never appear.
    out_ready = 1'b0;
    exp_plain_q.push_back(64'h0F0F0F0FF0F0F0F0);
    exp_out_q.push_back(32'hF0F0F0F0);
    run_block(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 64'h0);
    wait_valid(t);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_r_data", out_data, 32'h0F0F0F0F);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_outr");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Chain was cleared by reset, so a CBC block without IV load XORs with zero.
    exp_plain_q.push_back(64'h0000000100000002);
    exp_out_q.push_back(32'hFFFFFFFE);
    exp_out_q.push_back(32'hFFFFFFFD);
    run_block(32'h00000001, 32'h00000002, 1'b1, 1'b0, 64'h0);
    wait_idle();

    repeat (4) @(posedge clk);
    #1;
    chk("out_queue_left", exp_out_q.size(), 0);
    chk("plain_queue_left", exp_plain_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
